// File: rtl/wb_pkg.sv
// Shared Wishbone command-master constants: FSM encoding, default watchdog
// timeout and burst-length helper.
package wb_pkg;

    localparam int WB_TIMEOUT_DEFAULT = 255;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;

    // len is encoded as words-1, so a 9-bit count keeps 256-word bursts exact
    function automatic logic [8:0] burst_words(input logic [7:0] len);
        return {1'b0, len} + 9'd1;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus-progress watchdog: down-counter reloaded on clear or while disabled,
// expires after TIMEOUT consecutive enabled cycles without a clear.
module wb_watchdog #(
    parameter int TIMEOUT = wb_pkg::WB_TIMEOUT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_clear || !i_enable) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // fires during the TIMEOUT-th idle cycle, so the abort lands on the next edge
    assign o_expire = i_enable & ~i_clear & (cnt == '0);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone pipelined master: turns one command (read/write burst) into
// len+1 strobes, collects acks, and reports done or watchdog abort.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | ready for a command, bus released
// ST_ISSUE    | cycle open, strobing words until len+1 issued
// ST_WAIT_ACK | all words issued, collecting remaining acks
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = WB_TIMEOUT_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_we,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [7:0]            i_cmd_len,
    input  logic                  i_cmd_inc,

    input  logic                  i_wdata_valid,
    output logic                  o_wdata_ready,
    input  logic [31:0]           i_wdata,

    output logic                  o_rdata_valid,
    output logic [31:0]           o_rdata,

    output logic                  o_done,
    output logic                  o_err,

    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_WIDTH-1:0] o_wb_adr,
    output logic [31:0]           o_wb_data,
    input  logic                  i_wb_stall,
    input  logic                  i_wb_ack,
    input  logic [31:0]           i_wb_data
);

    logic [1:0] state;
    logic [7:0] lat_len;
    logic       lat_inc;
    logic [8:0] issued_cnt;
    logic [8:0] acked_cnt;
    logic [8:0] words;
    logic       issue;
    logic       ack_cnt;
    logic       wd_expire;

    assign words       = burst_words(lat_len);
    assign o_cmd_ready = (state == ST_IDLE);
    assign o_wb_stb    = (state == ST_ISSUE) & (o_wb_we ? i_wdata_valid : 1'b1);
    assign o_wb_data   = i_wdata;
    assign issue       = o_wb_stb & ~i_wb_stall;
    assign ack_cnt     = i_wb_ack & o_wb_cyc;
    // stb already implies ISSUE, and for writes it tracks wdata_valid
    assign o_wdata_ready = issue & o_wb_we;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (o_wb_cyc & (issue | ack_cnt)),
        .i_enable (o_wb_cyc),
        .o_expire (wd_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            lat_len       <= '0;
            lat_inc       <= 1'b0;
            issued_cnt    <= '0;
            acked_cnt     <= '0;
            o_wb_cyc      <= 1'b0;
            o_wb_we       <= 1'b0;
            o_wb_adr      <= '0;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_rdata_valid <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;

            if (ack_cnt) begin
                acked_cnt <= acked_cnt + 9'd1;
                if (!o_wb_we) begin
                    o_rdata_valid <= 1'b1;
                    o_rdata       <= i_wb_data;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        state      <= ST_ISSUE;
                        o_wb_cyc   <= 1'b1;
                        o_wb_we    <= i_cmd_we;
                        o_wb_adr   <= i_cmd_addr;
                        lat_len    <= i_cmd_len;
                        lat_inc    <= i_cmd_inc;
                        issued_cnt <= '0;
                        acked_cnt  <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (issue) begin
                        issued_cnt <= issued_cnt + 9'd1;
                        if (lat_inc) begin
                            o_wb_adr <= o_wb_adr + ADDR_WIDTH'(1);
                        end
                        if (issued_cnt + 9'd1 == words) begin
                            state <= ST_WAIT_ACK;
                        end
                    end
                end
                ST_WAIT_ACK: ;
                default: state <= ST_IDLE;
            endcase

            // a counted ack clears the watchdog, so abort and completion never coincide
            if (o_wb_cyc) begin
                if (wd_expire) begin
                    state    <= ST_IDLE;
                    o_wb_cyc <= 1'b0;
                    o_wb_we  <= 1'b0;
                    o_err    <= 1'b1;
                end else if (ack_cnt && (acked_cnt + 9'd1 == words)) begin
                    state    <= ST_IDLE;
                    o_wb_cyc <= 1'b0;
                    o_wb_we  <= 1'b0;
                    o_done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: width of Wishbone word address.
REQ-002 SHALL have parameter TIMEOUT, default 255: idle cycles without ack/issue progress before abort.
REQ-003 SHALL have port i_clk  in  1  clock, posedge.
REQ-004 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports i_cmd_valid in 1, o_cmd_ready out 1, i_cmd_we in 1, i_cmd_addr in ADDR_WIDTH, i_cmd_len in 8 (words-1), i_cmd_inc in 1 (address increment enable): command stream.
REQ-006 SHALL have ports i_wdata_valid in 1, o_wdata_ready out 1, i_wdata in 32: write-data stream.
REQ-007 SHALL have ports o_rdata_valid out 1, o_rdata out 32: read-data output, no backpressure.
REQ-008 SHALL have ports o_done out 1 and o_err out 1: single-cycle completion and timeout-abort pulses.
REQ-009 SHALL have Wishbone pipelined master ports o_wb_cyc, o_wb_stb, o_wb_we (out 1), o_wb_adr (out ADDR_WIDTH), o_wb_data (out 32), i_wb_stall, i_wb_ack (in 1), i_wb_data (in 32).

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT_ACK.
REQ-011 SHALL drive o_cmd_ready = 1 only in IDLE; a command is accepted on i_cmd_valid & o_cmd_ready.
REQ-012 SHALL latch we/addr/len/inc on acceptance, assert o_wb_cyc from the next cycle, enter ISSUE.
REQ-013 SHALL, in ISSUE, for reads hold o_wb_stb = 1; for writes o_wb_stb = i_wdata_valid, o_wb_data = i_wdata, o_wdata_ready = o_wb_stb & ~i_wb_stall.
REQ-014 SHALL count a word issued on o_wb_stb & ~i_wb_stall; on issue increment o_wb_adr by 1 (wrapping modulo 2^ADDR_WIDTH) only if inc latched.
REQ-015 SHALL move ISSUE -> WAIT_ACK after len+1 words issued; o_wb_stb = 0 outside ISSUE.
REQ-016 SHALL count acks via i_wb_ack & o_wb_cyc, including an ack in the same cycle as an issue; acks while o_wb_cyc = 0 are ignored.
REQ-017 SHALL, for reads, register i_wb_data to o_rdata and pulse o_rdata_valid one cycle after each counted ack.
REQ-018 SHALL, when acked count reaches len+1, deassert o_wb_cyc on the next cycle, pulse o_done in that same cycle, return to IDLE.
REQ-019 SHALL use 9-bit issue/ack counters so len = 255 (256 words) is exact.
REQ-020 SHALL run a watchdog cleared on every issue or counted ack while o_wb_cyc = 1; on reaching TIMEOUT it drops o_wb_cyc/o_wb_stb next cycle, pulses o_err (no o_done), returns to IDLE.
REQ-021 SHALL drive o_wdata_ready = 0 in all states except ISSUE with we latched.

Reset
REQ-022 SHALL, while i_rst = 1 at a clock edge, force IDLE, counters/watchdog 0, and outputs o_wb_cyc, o_wb_stb, o_wb_we, o_rdata_valid, o_done, o_err, o_wdata_ready = 0, o_cmd_ready = 1 after reset, o_wb_adr = 0, o_rdata = 0.
REQ-023 SHALL abort any in-flight transaction on reset without o_done/o_err pulses; late acks after reset are ignored.

Structure
REQ-024 SHALL place state encoding and default TIMEOUT constant in a shared wishbone package (wb_pkg).
REQ-025 SHALL implement the watchdog as sub-module wb_watchdog (clear, enable, expire).

Verification
REQ-026 Read len=3, inc=1, addr=0x10 against zero-stall slave acking every strobe with 0xDEADBEEF -> adr 0x10..0x13, cyc high exactly 5 cycles, four o_rdata_valid with 0xDEADBEEF, one o_done.
REQ-027 Write len=1, inc=0, addr=0x20, wdata 0x11111111 then 0x22222222 with 2-cycle valid gap -> two strobes to 0x20 in order, o_wdata_ready only on issue cycles, one o_done.
REQ-028 Read len=0 with i_wb_stall=1 for 3 cycles -> stb held 4 cycles, adr stable, single rdata, o_done.
REQ-029 Read len=1, slave never acks, TIMEOUT=8 -> o_err pulse after 8 idle cycles, cyc low, o_cmd_ready=1, no o_done.
REQ-030 i_rst asserted mid-burst (after 2 of 4 issues) -> cyc/stb low next cycle, no pulses, subsequent command completes normally.
REQ-031 Read len=255, inc=1, addr=0xFE (ADDR_WIDTH=8) -> 256 rdata, address wraps 0xFF->0x00, one o_done.
